// File: rtl/dcache_direct.sv
// Direct-mapped, write-back, write-allocate data cache, one word per line.
// Serves MEM-stage requests, fills/evicts over dREN/dWEN, and flushes dirty lines on halt.
module dcache_direct #(
    parameter int unsigned SETS  = 16,
    parameter int unsigned IDX_W = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload
);

    localparam int unsigned TAG_W = 32 - IDX_W - 2;
    localparam logic [IDX_W:0] FLUSH_LAST = (IDX_W + 1)'(SETS - 1);

    typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH, DONE} state_t;

    state_t state, next_state;

    logic [SETS-1:0]  valid;
    logic [SETS-1:0]  dirty;
    logic [TAG_W-1:0] tag_arr  [SETS];
    logic [31:0]      data_arr [SETS];
    logic [IDX_W:0]   flush_idx;

    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] fidx;
    logic [TAG_W-1:0] req_tag;
    logic             req;
    logic             hit;
    logic             advance;

    assign idx     = dmemaddr[IDX_W+1:2];
    assign req_tag = dmemaddr[31:IDX_W+2];
    assign fidx    = flush_idx[IDX_W-1:0];
    assign req     = dmemREN | dmemWEN;
    assign hit     = (state == IDLE) && !halt && valid[idx] && (tag_arr[idx] == req_tag) && req;
    // Clean lines step in one cycle; dirty lines wait for their write-back.
    assign advance = (state == FLUSH) && (!dirty[fidx] || !dwait);

    assign dhit     = hit;
    assign dmemload = data_arr[idx];
    assign flushed  = (state == DONE);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (halt)             next_state = FLUSH;
                else if (req && !hit) next_state = dirty[idx] ? WB : FETCH;
            end
            WB:    if (!dwait) next_state = FETCH;
            FETCH: if (!dwait) next_state = halt ? FLUSH : IDLE;
            FLUSH: if (advance && flush_idx == FLUSH_LAST) next_state = DONE;
            DONE:  next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        dREN   = 1'b0;
        dWEN   = 1'b0;
        daddr  = '0;
        dstore = '0;
        unique case (state)
            WB: begin
                dWEN   = 1'b1;
                daddr  = {tag_arr[idx], idx, 2'b00};
                dstore = data_arr[idx];
            end
            FETCH: begin
                dREN  = 1'b1;
                daddr = dmemaddr & ~32'h3;
            end
            FLUSH: begin
                if (dirty[fidx]) begin
                    dWEN   = 1'b1;
                    daddr  = {tag_arr[fidx], fidx, 2'b00};
                    dstore = data_arr[fidx];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid     <= '0;
            dirty     <= '0;
            flush_idx <= '0;
            for (int unsigned i = 0; i < SETS; i++) begin
                tag_arr[i]  <= '0;
                data_arr[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (hit && dmemWEN) begin
                        data_arr[idx] <= dmemstore;
                        dirty[idx]    <= 1'b1;
                    end
                end
                WB: if (!dwait) dirty[idx] <= 1'b0;
                FETCH: begin
                    if (!dwait) begin
                        data_arr[idx] <= dload;
                        tag_arr[idx]  <= req_tag;
                        valid[idx]    <= 1'b1;
                        dirty[idx]    <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (advance) begin
                        dirty[fidx] <= 1'b0;
                        flush_idx   <= flush_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_direct.sv
// Directed bench for dcache_direct with a small wait-state memory model.
module tb_dcache_direct;

    logic        clk = 1'b0;
    logic        nrst;
    logic        dmem_ren, dmem_wen, halt;
    logic [31:0] dmem_addr, dmem_store;
    logic        dhit, flushed, dren, dwen, dwait;
    logic [31:0] dmemload, daddr, dstore, dload;

    int errors = 0;
    int checks = 0;
    int lat = 2;

    logic [31:0] mem [0:255];
    logic        loaded = 1'b0;
    int          wcnt = 0;
    int          wr_cnt = 0;
    logic [31:0] wr_a [0:15];
    logic [31:0] wr_d [0:15];

    dcache_direct #(.SETS(16), .IDX_W(4)) dut (
        .CLK(clk), .nRST(nrst),
        .dmemREN(dmem_ren), .dmemWEN(dmem_wen), .dmemaddr(dmem_addr), .dmemstore(dmem_store),
        .halt(halt), .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .dREN(dren), .dWEN(dwen), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload)
    );

    always #5 clk = ~clk;

    assign dwait = (dren | dwen) && (wcnt < lat);
    assign dload = mem[daddr[9:2]];

    // Memory: preloaded once, then lat busy cycles per transfer; writes are logged.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h5000_0000 + i;
            mem[8'h40] <= 32'hDEADBEEF;
            mem[8'h50] <= 32'hCAFEF00D;
            loaded <= 1'b1;
        end else if (dren | dwen) begin
            if (wcnt < lat) wcnt <= wcnt + 1;
            else begin
                wcnt <= 0;
                if (dwen) begin
                    mem[daddr[9:2]] <= dstore;
                    wr_a[wr_cnt[3:0]] <= daddr;
                    wr_d[wr_cnt[3:0]] <= dstore;
                    wr_cnt <= wr_cnt + 1;
                end
            end
        end else wcnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic ren, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, output int miss_cyc, output int n_ren,
                          output int n_wen, output logic [31:0] rdata, output logic [31:0] wb_a,
                          output logic [31:0] wb_d, output logic [31:0] fe_a);
        logic got = 1'b0;
        miss_cyc = 0; n_ren = 0; n_wen = 0;
        rdata = '0; wb_a = '0; wb_d = '0; fe_a = '0;
        @(negedge clk);
        dmem_ren = ren; dmem_wen = wen; dmem_addr = addr; dmem_store = wdata;
        for (int i = 0; i < 100 && !got; i++) begin
            #1;
            if (dhit) begin
                got = 1'b1;
                rdata = dmemload;
            end else begin
                miss_cyc++;
                if (dren) begin
                    if (n_ren == 0) fe_a = daddr;
                    n_ren++;
                end
                if (dwen) begin
                    if (n_wen == 0) begin wb_a = daddr; wb_d = dstore; end
                    n_wen++;
                end
                @(negedge clk);
            end
        end
        check("req_completes", {31'b0, got}, 32'd1);
        @(posedge clk);
        #1;
        dmem_ren = 1'b0; dmem_wen = 1'b0;
    endtask

    initial begin
        int mc, nr, nw, cnt, base;
        logic [31:0] rd, wa, wd, fa;
        nrst = 1'b0; halt = 1'b0;
        dmem_ren = 1'b0; dmem_wen = 1'b0; dmem_addr = '0; dmem_store = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_dhit", {31'b0, dhit}, 0);
        check("rst_dren", {31'b0, dren}, 0);
        check("rst_dwen", {31'b0, dwen}, 0);
        check("rst_daddr", daddr, 0);
        check("rst_dstore", dstore, 0);
        check("rst_flushed", {31'b0, flushed}, 0);
        check("rst_dmemload", dmemload, 0);
        nrst = 1'b1;

        // Cold read with two busy cycles, then a re-read hit.
        lat = 2;
        do_req(1, 0, 32'h100, 0, mc, nr, nw, rd, wa, wd, fa);
        check("t1_miss_cycles", mc, 4);
        check("t1_dren_cycles", nr, 3);
        check("t1_no_dwen", nw, 0);
        check("t1_fetch_addr", fa, 32'h100);
        check("t1_rdata", rd, 32'hDEADBEEF);
        do_req(1, 0, 32'h100, 0, mc, nr, nw, rd, wa, wd, fa);
        check("t1_rehit_cycles", mc, 0);
        check("t1_rehit_rdata", rd, 32'hDEADBEEF);

        // Write hit, then read back.
        do_req(0, 1, 32'h100, 32'h12345678, mc, nr, nw, rd, wa, wd, fa);
        check("t2_whit_cycles", mc, 0);
        check("t2_whit_dwen", nw, 0);
        do_req(1, 0, 32'h100, 0, mc, nr, nw, rd, wa, wd, fa);
        check("t2_read_back", rd, 32'h12345678);

        // Conflict miss on dirty idx 0: write-back then fetch.
        lat = 1;
        do_req(1, 0, 32'h140, 0, mc, nr, nw, rd, wa, wd, fa);
        check("t3_miss_cycles", mc, 5);
        check("t3_dwen_cycles", nw, 2);
        check("t3_dren_cycles", nr, 2);
        check("t3_wb_addr", wa, 32'h100);
        check("t3_wb_data", wd, 32'h12345678);
        check("t3_fetch_addr", fa, 32'h140);
        check("t3_rdata", rd, 32'hCAFEF00D);

        // Write miss allocates, then the write lands on the hit cycle.
        do_req(0, 1, 32'h204, 32'hA5A5A5A5, mc, nr, nw, rd, wa, wd, fa);
        check("t4_miss_cycles", mc, 3);
        check("t4_dren_cycles", nr, 2);
        check("t4_no_dwen", nw, 0);
        check("t4_fetch_addr", fa, 32'h204);
        do_req(1, 0, 32'h204, 0, mc, nr, nw, rd, wa, wd, fa);
        check("t4_hit_cycles", mc, 0);
        check("t4_rdata", rd, 32'hA5A5A5A5);
        do_req(0, 1, 32'h30C, 32'h77777777, mc, nr, nw, rd, wa, wd, fa);
        check("t4_idx3_dren", nr, 2);

        // Halt: only idx 1 and idx 3 are written back.
        base = wr_cnt;
        @(negedge clk);
        halt = 1'b1;
        cnt = 0;
        #1;
        while (!flushed && cnt < 200) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        check("t5_flushed", {31'b0, flushed}, 1);
        check("t5_flush_cycles", cnt, 19);
        check("t5_wb_count", wr_cnt - base, 2);
        check("t5_wb0_addr", wr_a[base[3:0]], 32'h204);
        check("t5_wb0_data", wr_d[base[3:0]], 32'hA5A5A5A5);
        check("t5_wb1_addr", wr_a[4'(base + 1)], 32'h30C);
        check("t5_wb1_data", wr_d[4'(base + 1)], 32'h77777777);
        halt = 1'b0;
        dmem_ren = 1'b1; dmem_addr = 32'h140;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("t5_flushed_held", {31'b0, flushed}, 1);
            check("t5_done_dhit", {31'b0, dhit}, 0);
            check("t5_done_mem_idle", {30'b0, dren, dwen}, 0);
        end
        dmem_ren = 1'b0;

        // Reset in the middle of a fetch.
        @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        lat = 5;
        dmem_ren = 1'b1; dmem_addr = 32'h100;
        repeat (3) @(negedge clk);
        #1;
        check("t6_fetch_active", {31'b0, dren}, 1);
        #2;
        nrst = 1'b0;
        #1;
        check("t6_abort_dren", {31'b0, dren}, 0);
        check("t6_abort_daddr", daddr, 0);
        check("t6_abort_flushed", {31'b0, flushed}, 0);
        dmem_ren = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        lat = 1;
        do_req(1, 0, 32'h100, 0, mc, nr, nw, rd, wa, wd, fa);
        check("t6_miss_cycles", mc, 3);
        check("t6_dren_cycles", nr, 2);
        check("t6_rdata", rd, 32'h12345678);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
